// File: rtl/if_fetch_pkg.sv
// Shared constants, FSM state type and immediate decoders for the fetch stage.
package if_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    localparam logic [AddrLen-1:0] ZERO_WORD = '0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    function automatic logic [AddrLen-1:0] j_imm(input logic [InstLen-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [AddrLen-1:0] b_imm(input logic [InstLen-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Memory handshake plus IF/ID-facing signals of the fetch stage.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic               mem_req;
    logic [AddrLen-1:0] mem_addr;
    logic               mem_done;
    logic [InstLen-1:0] mem_inst;
    logic               if_id_stall;
    logic               failed;
    logic [AddrLen-1:0] ex_target;
    logic [AddrLen-1:0] if_pc;
    logic [InstLen-1:0] if_inst;
    logic               pred_jump_or_not;
    logic               if_stall;

    modport master (
        input  mem_done, mem_inst, if_id_stall, failed, ex_target,
        output mem_req, mem_addr, if_pc, if_inst, pred_jump_or_not, if_stall
    );

    modport slave (
        output mem_done, mem_inst, if_id_stall, failed, ex_target,
        input  mem_req, mem_addr, if_pc, if_inst, pred_jump_or_not, if_stall
    );

endinterface

// File: rtl/if_fetch_static_predictor.sv
// Static BTFN predictor: JAL and backward conditional branches are taken.
module if_fetch_static_predictor
    import if_fetch_pkg::*;
(
    input  logic [InstLen-1:0] inst_i,
    input  logic [AddrLen-1:0] pc_i,
    output logic               taken_o,
    output logic [AddrLen-1:0] target_o
);

    always_comb begin
        taken_o  = FALSE;
        target_o = pc_i + 32'd4;
        if (inst_i[6:0] == OP_JAL) begin
            taken_o  = TRUE;
            target_o = pc_i + j_imm(inst_i);
        end else if (inst_i[6:0] == OP_BRANCH && inst_i[31]) begin
            taken_o  = TRUE;
            target_o = pc_i + b_imm(inst_i);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding word request, static prediction,
// mispredict redirect and hold while IF/ID is stalled.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [AddrLen-1:0] RESET_PC    = 32'h0,
    parameter bit                 ENABLE_PRED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    if_fetch_if.master  bus
);

    state_e             state_q, state_d;
    logic [AddrLen-1:0] pc_q, pc_d;
    logic [AddrLen-1:0] next_pc_q, next_pc_d;
    logic               mem_req_q, mem_req_d;
    logic [AddrLen-1:0] mem_addr_q, mem_addr_d;
    logic [AddrLen-1:0] if_pc_q, if_pc_d;
    logic [InstLen-1:0] if_inst_q, if_inst_d;
    logic               pred_q, pred_d;
    logic               if_stall_q, if_stall_d;

    logic               sp_taken;
    logic [AddrLen-1:0] sp_target;
    logic               pred_taken;
    logic [AddrLen-1:0] pred_target;

    if_fetch_static_predictor u_pred (
        .inst_i   (bus.mem_inst),
        .pc_i     (pc_q),
        .taken_o  (sp_taken),
        .target_o (sp_target)
    );

    assign pred_taken  = ENABLE_PRED ? sp_taken  : FALSE;
    assign pred_target = ENABLE_PRED ? sp_target : pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            next_pc_q  <= RESET_PC;
            mem_req_q  <= FALSE;
            mem_addr_q <= ZERO_WORD;
            if_pc_q    <= ZERO_WORD;
            if_inst_q  <= ZERO_WORD;
            pred_q     <= FALSE;
            if_stall_q <= TRUE;
        end else if (rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            next_pc_q  <= next_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            pred_q     <= pred_d;
            if_stall_q <= if_stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.failed)        state_d = bus.mem_done ? ST_WAIT : ST_DROP;
                else if (bus.mem_done) state_d = ST_HOLD;
            end
            ST_DROP: if (bus.mem_done) state_d = ST_WAIT;
            ST_HOLD: if (bus.failed || !bus.if_id_stall) state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        next_pc_d  = next_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        pred_d     = pred_q;
        if_stall_d = if_stall_q;
        case (state_q)
            ST_IDLE: begin
                mem_req_d  = TRUE;
                if_stall_d = TRUE;
                pc_d       = bus.failed ? bus.ex_target : pc_q;
                mem_addr_d = bus.failed ? bus.ex_target : pc_q;
            end
            ST_WAIT: begin
                if (bus.failed) begin
                    // An in-flight request cannot be aborted; only reissue once it returns.
                    pc_d       = bus.ex_target;
                    if_stall_d = TRUE;
                    if (bus.mem_done) begin
                        mem_req_d  = TRUE;
                        mem_addr_d = bus.ex_target;
                    end
                end else if (bus.mem_done) begin
                    if_inst_d  = bus.mem_inst;
                    if_pc_d    = pc_q;
                    if_stall_d = FALSE;
                    mem_req_d  = FALSE;
                    pred_d     = pred_taken;
                    next_pc_d  = pred_target;
                end
            end
            ST_DROP: begin
                if (bus.failed) pc_d = bus.ex_target;
                if (bus.mem_done) begin
                    mem_req_d  = TRUE;
                    mem_addr_d = bus.failed ? bus.ex_target : pc_q;
                end
            end
            ST_HOLD: begin
                if (bus.failed) begin
                    pc_d       = bus.ex_target;
                    mem_req_d  = TRUE;
                    mem_addr_d = bus.ex_target;
                    if_stall_d = TRUE;
                end else if (!bus.if_id_stall) begin
                    pc_d       = next_pc_q;
                    mem_req_d  = TRUE;
                    mem_addr_d = next_pc_q;
                    if_stall_d = TRUE;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_req          = mem_req_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.if_pc            = if_pc_q;
    assign bus.if_inst          = if_inst_q;
    assign bus.pred_jump_or_not = pred_q;
    assign bus.if_stall         = if_stall_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: scoreboard of expected request addresses and
// presented instructions, popped by a monitor sampling 1ns after each edge.
module tb_if_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } pres_t;

    logic clk;
    logic rst_n;
    logic rdy;

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC    (32'h0),
        .ENABLE_PRED (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_addr_q[$];
    pres_t       pres_q[$];
    logic        prev_req = 1'b0;
    logic        prev_stall = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   {31'b0, bus.mem_req}, 32'h0);
        check_eq({tag, "_addr"},  bus.mem_addr, 32'h0);
        check_eq({tag, "_pc"},    bus.if_pc, 32'h0);
        check_eq({tag, "_inst"},  bus.if_inst, 32'h0);
        check_eq({tag, "_pred"},  {31'b0, bus.pred_jump_or_not}, 32'h0);
        check_eq({tag, "_stall"}, {31'b0, bus.if_stall}, 32'h1);
    endtask

    // Monitor: new request = req rises, or req stays high across a done edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.mem_req && (!prev_req || bus.mem_done)) begin
                $display("REQ  addr=%h", bus.mem_addr);
                check_eq("req_expected", {31'b0, exp_addr_q.size() != 0}, 32'h1);
                if (exp_addr_q.size() != 0) check_eq("req_addr", bus.mem_addr, exp_addr_q.pop_front());
            end
            if (!bus.if_stall && prev_stall) begin
                $display("PRES pc=%h inst=%h pred=%0d", bus.if_pc, bus.if_inst, bus.pred_jump_or_not);
                check_eq("pres_expected", {31'b0, pres_q.size() != 0}, 32'h1);
                if (pres_q.size() != 0) begin
                    pres_t e;
                    e = pres_q.pop_front();
                    check_eq("pres_pc",   bus.if_pc, e.pc);
                    check_eq("pres_inst", bus.if_inst, e.inst);
                    check_eq("pres_pred", {31'b0, bus.pred_jump_or_not}, {31'b0, e.pred});
                end
            end
        end
        prev_req   = bus.mem_req;
        prev_stall = bus.if_stall;
    end

    task automatic mem_reply(input logic [31:0] word, input int lat);
        repeat (lat) @(negedge clk);
        bus.mem_done = 1'b1;
        bus.mem_inst = word;
        @(negedge clk);
        bus.mem_done = 1'b0;
    endtask

    // One fetch: expect the presentation, then either consume or redirect from HOLD.
    task automatic fetch(input logic [31:0] word, input logic [31:0] pc, input logic pred,
                         input logic [31:0] next_addr, input logic redirect, input logic [31:0] target);
        pres_q.push_back('{pc: pc, inst: word, pred: pred});
        exp_addr_q.push_back(redirect ? target : next_addr);
        mem_reply(word, 3);
        if (redirect) begin
            bus.failed    = 1'b1;
            bus.ex_target = target;
        end
        @(negedge clk);
        bus.failed = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        rdy             = 1'b1;
        bus.mem_done    = 1'b0;
        bus.mem_inst    = 32'h0;
        bus.if_id_stall = 1'b0;
        bus.failed      = 1'b0;
        bus.ex_target   = 32'h0;
        exp_addr_q.push_back(32'h0);

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("req_after_release", {31'b0, bus.mem_req}, 32'h1);

        fetch(32'h0000_0013, 32'h000, 1'b0, 32'h004, 1'b0, 32'h0);
        fetch(32'h0000_0013, 32'h004, 1'b0, 32'h0,   1'b1, 32'h100);
        fetch(32'hFF9F_F0EF, 32'h100, 1'b1, 32'h0F8, 1'b0, 32'h0);  // JAL -8
        fetch(32'h0000_0013, 32'h0F8, 1'b0, 32'h0,   1'b1, 32'h200);
        fetch(32'hFE00_08E3, 32'h200, 1'b1, 32'h1F0, 1'b0, 32'h0);  // BEQ -16
        fetch(32'h0000_0013, 32'h1F0, 1'b0, 32'h0,   1'b1, 32'h200);
        fetch(32'h0000_0863, 32'h200, 1'b0, 32'h204, 1'b0, 32'h0);  // BEQ +16

        // JALR at 0x204 held by IF/ID for five cycles
        pres_q.push_back('{pc: 32'h204, inst: 32'h0000_80E7, pred: 1'b0});
        exp_addr_q.push_back(32'h208);
        bus.if_id_stall = 1'b1;
        mem_reply(32'h0000_80E7, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_inst",  bus.if_inst, 32'h0000_80E7);
            check_eq("hold_pc",    bus.if_pc, 32'h204);
            check_eq("hold_pred",  {31'b0, bus.pred_jump_or_not}, 32'h0);
            check_eq("hold_req",   {31'b0, bus.mem_req}, 32'h0);
            check_eq("hold_stall", {31'b0, bus.if_stall}, 32'h0);
        end
        bus.if_id_stall = 1'b0;
        @(negedge clk);
        check_eq("consume_addr", bus.mem_addr, 32'h208);

        fetch(32'h0000_0013, 32'h208, 1'b0, 32'h0, 1'b1, 32'h010);

        // Mispredict two cycles into WAIT at 0x10: outstanding word must be dropped
        @(negedge clk);
        bus.failed    = 1'b1;
        bus.ex_target = 32'h400;
        exp_addr_q.push_back(32'h400);
        @(negedge clk);
        bus.failed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("drop_addr",  bus.mem_addr, 32'h010);
            check_eq("drop_req",   {31'b0, bus.mem_req}, 32'h1);
            check_eq("drop_stall", {31'b0, bus.if_stall}, 32'h1);
            @(negedge clk);
        end
        mem_reply(32'hDEAD_BEEF, 0);
        check_eq("after_drop_addr",  bus.mem_addr, 32'h400);
        check_eq("after_drop_stall", {31'b0, bus.if_stall}, 32'h1);

        // failed together with mem_done: reissue immediately
        repeat (2) @(negedge clk);
        bus.failed    = 1'b1;
        bus.ex_target = 32'h500;
        exp_addr_q.push_back(32'h500);
        mem_reply(32'hBAD0_BAD0, 0);
        bus.failed = 1'b0;
        check_eq("fail_done_addr", bus.mem_addr, 32'h500);
        check_eq("fail_done_req",  {31'b0, bus.mem_req}, 32'h1);

        // rdy low mid-WAIT freezes everything, even a redirect
        @(negedge clk);
        rdy           = 1'b0;
        bus.failed    = 1'b1;
        bus.ex_target = 32'h999;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rdy0_req",   {31'b0, bus.mem_req}, 32'h1);
            check_eq("rdy0_addr",  bus.mem_addr, 32'h500);
            check_eq("rdy0_stall", {31'b0, bus.if_stall}, 32'h1);
        end
        rdy        = 1'b1;
        bus.failed = 1'b0;
        pres_q.push_back('{pc: 32'h500, inst: 32'h00A0_0093, pred: 1'b0});
        bus.if_id_stall = 1'b1;
        mem_reply(32'h00A0_0093, 2);

        // Asynchronous reset in the middle of HOLD
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_addr_q.push_back(32'h0);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.if_id_stall = 1'b0;
        @(negedge clk);
        fetch(32'h0000_0013, 32'h000, 1'b0, 32'h004, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        check_eq("addr_queue_drained", 32'(exp_addr_q.size()), 32'h0);
        check_eq("pres_queue_drained", 32'(pres_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
